seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Parametrised Moore serial-pattern detector. Generalises the fixed-sequence detector FSMs.
//  Pattern and length are run-time programmable up to PAT_W bits. Overlapping or non-overlapping
//  detection is selectable. A valid qualifier allows gaps in the bit stream.
//  A saturating match counter is provided. Sits between a serial input synchroniser and LED/HEX status logic.
// PARAMETERS
//  PAT_W  8   maximum pattern length in bits (>=2)
//  CNT_W  8   width of match_count
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  rst          in   1                 reset, synchronous, active-high
//  cfg_we       in   1                 load cfg_pat/cfg_len/cfg_ovl this cycle
//  cfg_pat      in   PAT_W             pattern; cfg_pat[len-1] = first bit received, cfg_pat[0] = last
//  cfg_len      in   $clog2(PAT_W+1)   pattern length; 0 = disabled; >PAT_W clamps to PAT_W
//  cfg_ovl      in   1                 1 = overlapping detection, 0 = non-overlapping
//  in_valid     in   1                 in_bit is sampled only when high
//  in_bit       in   1                 serial data bit
//  match        out  1                 Moore output, high while in state HIT
//  match_count  out  CNT_W             number of matches, saturating
//  state_dbg    out  2                 current FSM state encoding (for HEX display)
// BEHAVIOUR
//  Reset: hist=0, fill=0, pat=0, len=0, ovl=0, state=DISABLED, match=0, match_count=0.
//  Config write (cfg_we=1): registers pattern/length/mode, clears hist and fill, clears match_count.
//   Next state is DISABLED if clamped len==0, else FILLING. in_bit is ignored in a cfg_we cycle.
//  History: on in_valid, hist <= {hist[PAT_W-2:0], in_bit}; fill <= min(fill+1, PAT_W).
//  Compare: hit_now = (fill_next >= len) && (hist_next[len-1:0] == pat[len-1:0]).
//   Evaluated only on in_valid cycles.
//  States (2-bit): DISABLED=0, FILLING=1, ARMED=2, HIT=3.
//   DISABLED: stays until cfg_we with len>0. in_valid is ignored.
//   FILLING: on in_valid with hit_now -> HIT. Otherwise -> ARMED once fill_next >= len.
//   ARMED: on in_valid, hit_now -> HIT, else stays.
//   HIT: match=1. On in_valid, hit_now -> HIT (back-to-back), else ARMED/FILLING per fill.
//    Without in_valid, HIT -> ARMED (or FILLING if non-overlap cleared fill).
//  Non-overlap (ovl=0): the bit completing a match also clears fill to 0 (hist kept).
//   Following bits must refill len bits before the next hit.
//  Overlap (ovl=1): fill is not cleared; a hit can occur on the very next valid bit.
//  Latency: match rises in the cycle after the completing bit is sampled.
//   It stays high exactly 1 cycle per hit, unless consecutive valid bits each hit.
//  match_count increments in the same edge that enters/re-enters HIT. It saturates at 2^CNT_W-1.
//  Reset mid-stream overrides everything, including cfg_we and in_valid, on that edge.
//  len==1: every valid bit equal to pat[0] is a hit, in either mode.
//  No X: next-state default is DISABLED; all outputs are driven every cycle.
// STRUCTURE
//  Package seq_det_pkg: state localparams DISABLED/FILLING/ARMED/HIT, and function clamp_len().
//  Sub-module pattern_window: owns hist/fill shift logic and the masked compare.
//   Its interface is shift, clear_fill, clear_all, len, pat -> hit_now, full.
//  Top level holds config registers, FSM, counter and outputs.
// TESTING
//  1 Reset: assert rst 2 cycles -> match=0, match_count=0, state_dbg=0. Valid bits ignored while disabled.
//  2 len=4, pat=4'b1011, ovl=1. Stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7, match_count=2.
//  3 Same stream with ovl=0 -> single pulse after bit 4, match_count=1.
//  4 pat=2'b11, len=2, ovl=1. Stream 1,1,1,1 -> match high 3 consecutive cycles, count=3.
//    Same with ovl=0 -> 2 separate pulses, count=2.
//  5 Gaps: pattern 1011 with in_valid low 3 cycles between each bit -> exactly 1 pulse, 1 cycle wide.
//  6 CNT_W=2 with 5 matches -> count saturates at 3.
//    cfg_we mid-pattern -> fill cleared, no false hit.
//    rst during HIT -> match=0 on the next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial-pattern detector:
// FSM state encoding and the pattern-length clamp.
package seq_det_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILLING  = 2'd1,
    ARMED    = 2'd2,
    HIT      = 2'd3
  } state_t;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Shift history of received bits plus fill level, and the length-masked
// compare of the post-shift window against the programmed pattern.
module pattern_window #(
  parameter int PAT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift,
  input  logic                         in_bit,
  input  logic                         clear_fill,
  input  logic                         clear_all,
  input  logic [$clog2(PAT_W+1)-1:0]   len,
  input  logic [PAT_W-1:0]             pat,
  output logic                         hit_now,
  output logic                         full
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist, hist_next, mask;
  logic [LEN_W-1:0] fill, fill_next;

  always_comb begin
    hist_next = hist;
    fill_next = fill;
    if (shift) begin
      hist_next = {hist[PAT_W-2:0], in_bit};
      if (fill != LEN_W'(PAT_W)) fill_next = fill + 1'b1;
    end
  end

  // Only the newest len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
  end

  assign full    = (fill_next >= len);
  assign hit_now = (len != '0) && full && (((hist_next ^ pat) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_next;
      fill <= clear_fill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time programmable Moore pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [PAT_W-1:0]             cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_ovl,
  input  logic                         in_valid,
  input  logic                         in_bit,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic [1:0]                   state_dbg
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  state_t           state, state_next;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len, cfg_len_c;
  logic             ovl;
  logic             shift, hit, hit_now, full, clear_fill;

  assign cfg_len_c  = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
  // A config write takes priority over the data bit in the same cycle.
  assign shift      = in_valid && !cfg_we && (state != DISABLED);
  assign hit        = shift && hit_now;
  assign clear_fill = hit && !ovl;

  pattern_window #(.PAT_W(PAT_W)) u_window (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .in_bit     (in_bit),
    .clear_fill (clear_fill),
    .clear_all  (cfg_we),
    .len        (len),
    .pat        (pat),
    .hit_now    (hit_now),
    .full       (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= '0;
      len <= '0;
      ovl <= 1'b0;
    end else if (cfg_we) begin
      pat <= cfg_pat;
      len <= cfg_len_c;
      ovl <= cfg_ovl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DISABLED;
    else     state <= state_next;
  end

  always_comb begin
    state_next = DISABLED;
    if (cfg_we) begin
      state_next = (cfg_len_c == '0) ? DISABLED : FILLING;
    end else begin
      case (state)
        DISABLED: state_next = DISABLED;
        FILLING:  state_next = hit ? HIT : ((shift && full) ? ARMED : FILLING);
        ARMED:    state_next = hit ? HIT : ARMED;
        // full reflects the post-shift fill, or the held fill when idle.
        HIT:      state_next = hit ? HIT : (full ? ARMED : FILLING);
        default:  state_next = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      match_count <= '0;
    end else if (hit && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + 1'b1;
    end
  end

  assign match     = (state == HIT);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed scenarios and random traffic compared each
// cycle against a bit-queue reference model of the detector.
module tb_seq_pattern_detector;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovl = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state_dbg;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic       m_en = 1'b0;
  int         m_len = 0;
  logic [7:0] m_pat = '0;
  logic       m_ovl = 1'b0;
  logic       hq[$];
  int         m_since = 0;
  logic       m_hit = 1'b0;
  int         m_cnt = 0;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_ovl     (cfg_ovl),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (match_count),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_step(input logic r, input logic we, input logic [7:0] p,
                            input logic [3:0] l, input logic o, input logic v, input logic b);
    if (r) begin
      m_en = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0;
      hq.delete(); m_since = 0; m_hit = 1'b0; m_cnt = 0;
    end else if (we) begin
      m_len = (l > 4'd8) ? 8 : int'(l);
      m_pat = p; m_ovl = o;
      hq.delete(); m_since = 0; m_cnt = 0; m_hit = 1'b0;
      m_en = (m_len != 0);
    end else if (m_en && v) begin
      hq.push_back(b);
      if (hq.size() > PAT_W) void'(hq.pop_front());
      if (m_since < PAT_W) m_since++;
      m_hit = (m_since >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (m_hit && (hq[hq.size()-1-i] !== m_pat[i])) m_hit = 1'b0;
      end
      if (m_hit) begin
        if (m_cnt < 3) m_cnt++;
        if (!m_ovl) m_since = 0;
      end
    end else begin
      m_hit = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_state();
    if (!m_en)                return 8'd0;
    else if (m_hit)           return 8'd3;
    else if (m_since >= m_len) return 8'd2;
    else                      return 8'd1;
  endfunction

  task automatic apply_stimulus(input string tag, input logic r, input logic we,
                                input logic [7:0] p, input logic [3:0] l, input logic o,
                                input logic v, input logic b);
    @(negedge clk);
    rst = r; cfg_we = we; cfg_pat = p; cfg_len = l; cfg_ovl = o;
    in_valid = v; in_bit = b;
    @(posedge clk);
    model_step(r, we, p, l, o, v, b);
    #1;
    check_output({tag, "_match"}, {7'd0, match}, {7'd0, m_hit});
    check_output({tag, "_count"}, {6'd0, match_count}, 8'(m_cnt));
    check_output({tag, "_state"}, {6'd0, state_dbg}, model_state());
  endtask

  task automatic send_bit(input string tag, input logic v, input logic b);
    apply_stimulus(tag, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, b);
  endtask

  task automatic configure(input string tag, input logic [7:0] p, input logic [3:0] l, input logic o);
    apply_stimulus(tag, 1'b0, 1'b1, p, l, o, 1'b0, 1'b0);
  endtask

  task automatic send_stream(input string tag, input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(tag, 1'b1, bits[i]);
  endtask

  initial begin
    logic [7:0] rp;
    logic [3:0] rl;

    // Reset, then valid bits while disabled are ignored
    apply_stimulus("reset", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus("reset", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit("disabled", 1'b1, 1'b1);
    check_output("disabled_state", {6'd0, state_dbg}, 8'd0);

    // 1011 overlapping over stream 1011011
    configure("ovl_cfg", 8'b1011, 4'd4, 1'b1);
    send_stream("ovl", 8'b1011011, 7);
    check_output("ovl_total", {6'd0, match_count}, 8'd2);

    configure("novl_cfg", 8'b1011, 4'd4, 1'b0);
    send_stream("novl", 8'b1011011, 7);
    check_output("novl_total", {6'd0, match_count}, 8'd1);

    configure("b2b_cfg", 8'b11, 4'd2, 1'b1);
    send_stream("b2b", 8'b1111, 4);
    check_output("b2b_total", {6'd0, match_count}, 8'd3);

    configure("b2b_novl_cfg", 8'b11, 4'd2, 1'b0);
    send_stream("b2b_novl", 8'b1111, 4);
    check_output("b2b_novl_total", {6'd0, match_count}, 8'd2);

    // Gaps between valid bits
    configure("gap_cfg", 8'b1011, 4'd4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      rp = 8'b1011;
      send_bit("gap", 1'b1, rp[i]);
      for (int g = 0; g < 3; g++) send_bit("gap_idle", 1'b0, 1'b0);
    end
    check_output("gap_total", {6'd0, match_count}, 8'd1);

    // Saturation at 3 with len==1
    configure("sat_cfg", 8'b1, 4'd1, 1'b0);
    send_stream("sat", 8'b11111, 5);
    check_output("sat_total", {6'd0, match_count}, 8'd3);

    // Reconfigure mid-pattern: no false hit
    configure("mid_cfg", 8'b1011, 4'd4, 1'b1);
    send_stream("mid", 8'b101, 3);
    configure("mid_recfg", 8'b1011, 4'd4, 1'b1);
    send_bit("mid_after", 1'b1, 1'b1);
    check_output("mid_nohit", {7'd0, match}, 8'd0);

    // Reset while in HIT
    configure("rsthit_cfg", 8'b11, 4'd2, 1'b1);
    send_stream("rsthit", 8'b11, 2);
    check_output("rsthit_inhit", {6'd0, state_dbg}, 8'd3);
    apply_stimulus("rsthit_rst", 1'b1, 1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
    check_output("rsthit_match", {7'd0, match}, 8'd0);

    // Length above PAT_W clamps to PAT_W
    configure("clamp_cfg", 8'hA5, 4'd12, 1'b1);
    send_stream("clamp", 8'hA5, 8);
    check_output("clamp_total", {6'd0, match_count}, 8'd1);

    // Random traffic with occasional reconfiguration and reset
    configure("rnd_cfg", 8'b101, 4'd3, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_stimulus("rnd_rst", 1'b1, 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      end else if ($urandom_range(0, 59) == 0) begin
        rl = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
        rp = 8'($urandom);
        apply_stimulus("rnd_cfg", 1'b0, 1'b1, rp, rl, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        send_bit("rnd", ($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
